// File: rtl/wb_mem_sequencer.sv
// ============================================================================
// Module  : wb_mem_sequencer
// Brief   : Serialises up to four writeback store operands into the WBAQ,
//           one per cycle, lowest operand index first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [3:0]              mem_req,
    input  logic [4*DATA_WIDTH-1:0] inp_data,
    input  logic [4*ADDR_WIDTH-1:0] inp_addr,
    input  logic [1:0]              inp_size,
    input  logic                    flush,
    input  logic                    wbaq_full,
    output logic                    wbaq_wr,
    output logic [DATA_WIDTH-1:0]   wbaq_data,
    output logic [ADDR_WIDTH-1:0]   wbaq_addr,
    output logic [1:0]              wbaq_size,
    output logic                    stall,
    output logic                    done,
    output logic                    busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_pend;
    logic [3:0]              w_pend_nxt;
    logic [4*DATA_WIDTH-1:0] r_data;
    logic [4*ADDR_WIDTH-1:0] r_addr;
    logic [1:0]              r_size;

    logic                    w_capture;
    logic                    w_issue;
    logic [1:0]              w_sel;
    logic [3:0]              w_sel_oh;
    logic [3:0]              w_pend_left;

    // Lowest-index pending operand wins; scan downward so the last hit is the lowest.
    always_comb begin
        w_sel    = 2'd0;
        w_sel_oh = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel    = 2'(i);
                w_sel_oh = 4'b0001 << i;
            end
        end
    end

    assign w_capture   = (r_state == S_IDLE) && valid_in && !flush && (mem_req != 4'd0);
    assign w_issue     = (r_state == S_ISSUE) && (r_pend != 4'd0) && !wbaq_full;
    assign w_pend_left = r_pend & ~w_sel_oh;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_ISSUE;
                    w_pend_nxt  = mem_req;
                end
            end
            S_ISSUE: begin
                // flush and new requests are deliberately not looked at here:
                // the instruction has already committed.
                if (r_pend == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else if (w_issue) begin
                    w_pend_nxt = w_pend_left;
                    if (w_pend_left == 4'd0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pend  <= 4'd0;
            r_data  <= '0;
            r_addr  <= '0;
            r_size  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_capture) begin
                r_data <= inp_data;
                r_addr <= inp_addr;
                r_size <= inp_size;
            end
        end
    end

    // Enqueue payload is zeroed whenever no write is strobed.
    assign wbaq_wr   = w_issue;
    assign wbaq_data = w_issue ? r_data[w_sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wbaq_addr = w_issue ? r_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign wbaq_size = w_issue ? r_size : 2'd0;
    assign done      = w_issue && (w_pend_left == 4'd0);
    assign stall     = (r_state == S_ISSUE);
    assign busy      = (r_state == S_ISSUE);

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_sequencer.sv
// ============================================================================
// Module  : tb_wb_mem_sequencer
// Brief   : Self-checking bench for wb_mem_sequencer using a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mem_sequencer;

    localparam int DW = 64;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [3:0]      mem_req;
    logic [4*DW-1:0] inp_data;
    logic [4*AW-1:0] inp_addr;
    logic [1:0]      inp_size;
    logic            flush;
    logic            wbaq_full;
    logic            wbaq_wr;
    logic [DW-1:0]   wbaq_data;
    logic [AW-1:0]   wbaq_addr;
    logic [1:0]      wbaq_size;
    logic            stall;
    logic            done;
    logic            busy;

    always #5 clk = ~clk;

    wb_mem_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .mem_req   (mem_req),
        .inp_data  (inp_data),
        .inp_addr  (inp_addr),
        .inp_size  (inp_size),
        .flush     (flush),
        .wbaq_full (wbaq_full),
        .wbaq_wr   (wbaq_wr),
        .wbaq_data (wbaq_data),
        .wbaq_addr (wbaq_addr),
        .wbaq_size (wbaq_size),
        .stall     (stall),
        .done      (done),
        .busy      (busy)
    );

    // Reference model: the outstanding stores of the current instruction, in issue order.
    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } store_t;

    store_t        mq[$];
    logic [1:0]    m_size;

    logic          e_wr, e_done, e_stall, e_busy;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_size;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [4*DW-1:0] rand_data();
        logic [4*DW-1:0] v;
        for (int i = 0; i < 4*DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [4*AW-1:0] rand_addr();
        logic [4*AW-1:0] v;
        for (int i = 0; i < 4; i++) v[i*AW +: AW] = AW'($urandom);
        return v;
    endfunction

    // Applies inputs mid-cycle and derives the expected outputs for that cycle.
    task automatic drive(input logic v, input logic [3:0] r, input logic fl, input logic fu,
                         input logic [4*DW-1:0] d, input logic [4*AW-1:0] a, input logic [1:0] sz);
        @(negedge clk);
        valid_in  = v;
        mem_req   = r;
        flush     = fl;
        wbaq_full = fu;
        inp_data  = d;
        inp_addr  = a;
        inp_size  = sz;
        #1;
        e_busy  = (mq.size() != 0);
        e_stall = e_busy;
        e_wr    = e_busy && !fu;
        e_done  = e_wr && (mq.size() == 1);
        e_data  = e_wr ? mq[0].d : '0;
        e_addr  = e_wr ? mq[0].a : '0;
        e_size  = e_wr ? m_size : 2'd0;
    endtask

    task automatic tick();
        if (mq.size() != 0) begin
            if (!wbaq_full) void'(mq.pop_front());
        end else if (valid_in && !flush && mem_req != 4'd0) begin
            m_size = inp_size;
            for (int i = 0; i < 4; i++)
                if (mem_req[i]) mq.push_back('{inp_data[i*DW +: DW], inp_addr[i*AW +: AW]});
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_in = 1'b0; mem_req = 4'd0; flush = 1'b0; wbaq_full = 1'b0;
        inp_data = '0; inp_addr = '0; inp_size = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({wbaq_wr, done, stall, busy, wbaq_data, wbaq_addr, wbaq_size} !== '0)
            $display("FAIL reset_outputs: got wr=%b done=%b stall=%b busy=%b data=%h addr=%h size=%b, want all zero",
                     wbaq_wr, done, stall, busy, wbaq_data, wbaq_addr, wbaq_size);
        else n_pass++;
        rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_two_stores();
        logic [4*AW-1:0] a;
        a = rand_addr();
        a[0*AW +: AW] = 32'h1000;
        a[2*AW +: AW] = 32'h2000;
        drive(1'b1, 4'b0101, 1'b0, 1'b0, rand_data(), a, 2'b10);
        n_checks++;
        if ({wbaq_wr, stall} !== 2'b00)
            $display("FAIL two_capture_cycle: got wr=%b stall=%b, want 0 0", wbaq_wr, stall);
        else n_pass++;
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
            n_checks++;
            if ({wbaq_wr, done, stall, busy} !== {e_wr, e_done, e_stall, e_busy})
                $display("FAIL two_ctrl c%0d: got wr/done/stall/busy=%b%b%b%b, want %b%b%b%b",
                         c, wbaq_wr, done, stall, busy, e_wr, e_done, e_stall, e_busy);
            else n_pass++;
            n_checks++;
            if ({wbaq_data, wbaq_addr, wbaq_size} !== {e_data, e_addr, e_size})
                $display("FAIL two_payload c%0d: got %h/%h/%b, want %h/%h/%b",
                         c, wbaq_data, wbaq_addr, wbaq_size, e_data, e_addr, e_size);
            else n_pass++;
            if (c < 2) begin
                n_checks++;
                if (wbaq_addr !== (c == 0 ? 32'h1000 : 32'h2000) || wbaq_size !== 2'b10 || done !== (c == 1))
                    $display("FAIL two_fixed c%0d: got addr=%h size=%b done=%b", c, wbaq_addr, wbaq_size, done);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        drive(1'b1, 4'b1111, 1'b0, 1'b0, rand_data(), rand_addr(), 2'(($urandom)));
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 4'd0, 1'b0, (c < 3), rand_data(), rand_addr(), 2'b00);
            n_checks++;
            if ({wbaq_wr, done, stall, busy} !== {e_wr, e_done, e_stall, e_busy})
                $display("FAIL full_ctrl c%0d: got wr/done/stall/busy=%b%b%b%b, want %b%b%b%b",
                         c, wbaq_wr, done, stall, busy, e_wr, e_done, e_stall, e_busy);
            else n_pass++;
            n_checks++;
            if ({wbaq_data, wbaq_addr, wbaq_size} !== {e_data, e_addr, e_size})
                $display("FAIL full_payload c%0d: got %h/%h/%b, want %h/%h/%b",
                         c, wbaq_data, wbaq_addr, wbaq_size, e_data, e_addr, e_size);
            else n_pass++;
            n_checks++;
            if (done !== (c == 6) || wbaq_wr !== (c >= 3 && c <= 6))
                $display("FAIL full_timing c%0d: got wr=%b done=%b", c, wbaq_wr, done);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush_capture();
        drive(1'b1, 4'b0010, 1'b1, 1'b0, rand_data(), rand_addr(), 2'b01);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
            n_checks++;
            if ({wbaq_wr, stall, busy} !== 3'b000)
                $display("FAIL flush_capture c%0d: got wr=%b stall=%b busy=%b, want 000", c, wbaq_wr, stall, busy);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush_in_issue();
        logic [4*DW-1:0] d;
        d = rand_data();
        drive(1'b1, 4'b1000, 1'b0, 1'b0, d, rand_addr(), 2'b11);
        tick();
        drive(1'b1, 4'b0001, 1'b1, 1'b0, rand_data(), rand_addr(), 2'b00);
        n_checks++;
        if ({wbaq_wr, done, wbaq_data, wbaq_size} !== {2'b11, d[3*DW +: DW], 2'b11})
            $display("FAIL flush_issue: got wr=%b done=%b data=%h size=%b, want 1 1 %h 11",
                     wbaq_wr, done, wbaq_data, wbaq_size, d[3*DW +: DW]);
        else n_pass++;
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
            n_checks++;
            if ({wbaq_wr, stall, busy} !== 3'b000)
                $display("FAIL flush_issue_after c%0d: got wr=%b stall=%b busy=%b, want 000", c, wbaq_wr, stall, busy);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b0111, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b10);
        tick();
        drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
        tick();
        drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({wbaq_wr, done, stall, busy, wbaq_data, wbaq_addr, wbaq_size} !== '0)
            $display("FAIL reset_mid: got wr=%b done=%b stall=%b busy=%b data=%h addr=%h size=%b, want all zero",
                     wbaq_wr, done, stall, busy, wbaq_data, wbaq_addr, wbaq_size);
        else n_pass++;
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b00);
            n_checks++;
            if ({wbaq_wr, stall, busy} !== 3'b000)
                $display("FAIL reset_release c%0d: got wr=%b stall=%b busy=%b, want 000", c, wbaq_wr, stall, busy);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_zero_req();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'd0, 1'b0, 1'b0, rand_data(), rand_addr(), 2'b11);
            n_checks++;
            if ({wbaq_wr, done, stall, busy} !== 4'b0000)
                $display("FAIL zero_req c%0d: got wr/done/stall/busy=%b%b%b%b, want 0000", c, wbaq_wr, done, stall, busy);
            else n_pass++;
            tick();
        end
    endtask

    // Shared by back-to-back and random traffic: compare every output against the model.
    task automatic test_traffic(input string tag, input int cycles, input bit always_valid);
        for (int c = 0; c < cycles; c++) begin
            drive(always_valid ? 1'b1 : 1'($urandom_range(0, 1)), 4'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 3),
                  rand_data(), rand_addr(), 2'($urandom));
            n_checks++;
            if ({wbaq_wr, done, stall, busy} !== {e_wr, e_done, e_stall, e_busy})
                $display("FAIL %s_ctrl c%0d: got wr/done/stall/busy=%b%b%b%b, want %b%b%b%b",
                         tag, c, wbaq_wr, done, stall, busy, e_wr, e_done, e_stall, e_busy);
            else n_pass++;
            n_checks++;
            if ({wbaq_data, wbaq_addr, wbaq_size} !== {e_data, e_addr, e_size})
                $display("FAIL %s_payload c%0d: got %h/%h/%b, want %h/%h/%b",
                         tag, c, wbaq_data, wbaq_addr, wbaq_size, e_data, e_addr, e_size);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        test_traffic("b2b", 60, 1'b1);
    endtask

    task automatic test_random();
        test_traffic("rand", 300, 1'b0);
    endtask

    initial begin
        test_reset();
        test_two_stores();
        test_full_stall();
        test_flush_capture();
        test_flush_in_issue();
        test_reset_mid();
        test_zero_req();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_mem_sequencer.md
WB_MEM_SEQUENCER -- requirements
Module: wb_mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each store-data operand.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of each store address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port valid_in  input  1  writeback instruction present.
REQ-006 SHALL have port mem_req  input  4  per-operand store request (bit i = operand i+1 is a memory destination with wb set).
REQ-007 SHALL have port inp_data  input  4*DATA_WIDTH  store data, operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port inp_addr  input  4*ADDR_WIDTH  store addresses, same packing as inp_data.
REQ-009 SHALL have port inp_size  input  2  store size code (00=1B, 01=2B, 10=4B, 11=8B), shared by all operands.
REQ-010 SHALL have port flush  input  1  resteer; blocks capture in the same cycle.
REQ-011 SHALL have port wbaq_full  input  1  write-back address queue cannot accept this cycle.
REQ-012 SHALL have port wbaq_wr  output  1  enqueue strobe to WBAQ.
REQ-013 SHALL have port wbaq_data  output  DATA_WIDTH  enqueued store data.
REQ-014 SHALL have port wbaq_addr  output  ADDR_WIDTH  enqueued store address.
REQ-015 SHALL have port wbaq_size  output  2  enqueued store size.
REQ-016 SHALL have port stall  output  1  holds the writeback stage latch.
REQ-017 SHALL have port done  output  1  one-cycle pulse: last store of the instruction enqueued.
REQ-018 SHALL have port busy  output  1  FSM in ISSUE.

Function
REQ-019 SHALL implement FSM with states IDLE and ISSUE.
REQ-020 In IDLE, SHALL capture mem_req, inp_data, inp_addr, inp_size into internal registers and go to ISSUE when valid_in=1, flush=0, mem_req!=0.
REQ-021 In IDLE with valid_in=0, flush=1, or mem_req=0, SHALL capture nothing and remain in IDLE.
REQ-022 In ISSUE, when pending mask!=0 and wbaq_full=0, SHALL assert wbaq_wr for the lowest-index pending operand and clear its pending bit at that edge.
REQ-023 wbaq_data, wbaq_addr, wbaq_size SHALL be driven from captured registers of the selected operand combinationally in the same cycle as wbaq_wr.
REQ-024 When wbaq_wr=0, wbaq_data/wbaq_addr SHALL be 0 and wbaq_size SHALL be 00.
REQ-025 In ISSUE with wbaq_full=1, SHALL hold pending mask and all outputs except stall/busy deasserted-write; wbaq_wr=0, no bit cleared.
REQ-026 SHALL assert done in the cycle that enqueues the last pending bit and return to IDLE at that edge.
REQ-027 First enqueue SHALL occur the cycle after capture; N requested stores with wbaq_full=0 SHALL complete in exactly N ISSUE cycles.
REQ-028 stall SHALL equal 1 in every ISSUE cycle and 0 in IDLE; busy SHALL equal (state==ISSUE).
REQ-029 flush SHALL NOT cancel or alter an in-progress ISSUE sequence (instruction already committed).
REQ-030 Inputs valid_in, mem_req, inp_* SHALL be ignored while in ISSUE.
REQ-031 Back-to-back: a new request SHALL be captured no earlier than the cycle after done (first IDLE cycle).
REQ-032 wbaq_wr SHALL never assert in IDLE.

Reset
REQ-033 On rst=0, SHALL asynchronously enter IDLE, clear pending mask and captured registers, and drive wbaq_wr=0, done=0, stall=0, busy=0, wbaq_data=0, wbaq_addr=0, wbaq_size=00.
REQ-034 Reset asserted mid-ISSUE SHALL discard remaining pending stores; none issued after rst release until a new capture.

Verification
REQ-035 mem_req=4'b0101, addr1=0x1000, addr3=0x2000, size=10, wbaq_full=0 -> cycle+1 wbaq_wr addr 0x1000; cycle+2 wbaq_wr addr 0x2000, done=1; stall=1 for exactly 2 cycles.
REQ-036 mem_req=4'b1111, wbaq_full=1 for first 3 ISSUE cycles then 0 -> no wbaq_wr for 3 cycles, then 4 consecutive writes in order operand1..4, done on the 4th.
REQ-037 valid_in=1, mem_req=4'b0010, flush=1 -> no capture, wbaq_wr=0, stall=0 on following cycles.
REQ-038 mem_req=4'b1000 in ISSUE, flush=1 and new valid_in with mem_req=4'b0001 applied -> operand4 store issued, done=1; new request not captured.
REQ-039 rst=0 asynchronously mid-ISSUE after 1 of 3 stores -> outputs zero immediately; after release, no further wbaq_wr.
REQ-040 valid_in=1, mem_req=0 -> remains IDLE, stall=0, done=0.
